// File: rtl/scpool_nch.sv
// scpool_nch -- multi-channel pooling comparator.
//
// Pops one window of kernel_size vectors from an upstream FIFO. Each of the
// CHANNELS lanes is reduced independently to its maximum (mode=0) or its
// minimum (mode=1). The reduced vector is presented once per window, on a
// registered result together with a one-cycle result_valid pulse.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   start         one-cycle pulse that begins a window (honoured only in IDLE)
//   mode          0 = max, 1 = min; latched on an accepted start
//   kernel_size   elements per window; latched on an accepted start, 0 is ignored
//   fifo_empty    upstream FIFO empty flag
//   reads_en      FIFO pop strobe, one cycle per element
//   data          FIFO output vector, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_ready    data is valid this cycle (one or more cycles after reads_en)
//   result        registered reduced vector, held until the next window ends
//   result_valid  one-cycle pulse when result updates
//   busy          high whenever the block is not IDLE
module scpool_nch #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int FLOAT      = 1,
  parameter int KS_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           mode,
  input  logic [KS_WIDTH-1:0]            kernel_size,
  input  logic                           fifo_empty,
  output logic                           reads_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data,
  input  logic                           data_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] result,
  output logic                           result_valid,
  output logic                           busy
);

  localparam int VW = CHANNELS * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] SIGN_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [KS_WIDTH-1:0]   KS_ONE    = KS_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Maps an element onto an unsigned key whose natural order is the element
  // order. Half-float: negatives are inverted so larger magnitude sorts lower,
  // positives get the sign bit set so they sort above every negative. This is
  // a total order (-0 < +0, NaNs ordered by bit pattern). Integers: flipping
  // the sign bit turns a signed compare into an unsigned one.
  function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] k;
    if (FLOAT != 0) begin
      if (x[DATA_WIDTH-1]) begin
        k = ~x;
      end else begin
        k = x ^ SIGN_MASK;
      end
    end else begin
      k = x ^ SIGN_MASK;
    end
    return k;
  endfunction

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [KS_WIDTH-1:0]   ks_q, ks_d;
  logic [KS_WIDTH-1:0]   count_q, count_d;
  logic [KS_WIDTH-1:0]   count_inc_s;
  logic [VW-1:0]         acc_q, acc_d;
  logic [VW-1:0]         merged_s;
  logic [VW-1:0]         result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic                  busy_q, busy_d;

  assign count_inc_s = count_q + KS_ONE;

  // Per-lane merge of the incoming element into the accumulator. The first
  // element of a window always loads, so no seed value biases the result;
  // later elements replace only on a strict win, so ties keep the earlier one.
  always_comb begin
    merged_s = acc_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (count_q == '0) begin
        merged_s[i*DATA_WIDTH +: DATA_WIDTH] = data[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (mode_q
                   ? (order_key(data[i*DATA_WIDTH +: DATA_WIDTH]) <
                      order_key(acc_q[i*DATA_WIDTH +: DATA_WIDTH]))
                   : (order_key(data[i*DATA_WIDTH +: DATA_WIDTH]) >
                      order_key(acc_q[i*DATA_WIDTH +: DATA_WIDTH]))) begin
        merged_s[i*DATA_WIDTH +: DATA_WIDTH] = data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        merged_s[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Window sequencer: next state, latched window parameters and outputs.
  // reads_en is decoded from the current state and fifo_empty so that it can
  // never fire against an empty FIFO.
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    ks_d           = ks_q;
    count_d        = count_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    reads_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (kernel_size != '0)) begin
          mode_d  = mode;
          ks_d    = kernel_size;
          count_d = '0;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (!fifo_empty) begin
          reads_en = 1'b1;
          state_d  = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (data_ready) begin
          acc_d = merged_s;
          // count never reaches ks_q, so count+1 cannot wrap for a legal size
          if (count_inc_s == ks_q) begin
            state_d = S_DONE;
          end else begin
            count_d = count_inc_s;
            state_d = S_REQ;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        result_d       = acc_q;
        result_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset abandons any window in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mode_q         <= 1'b0;
      ks_q           <= '0;
      count_q        <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      ks_q           <= ks_d;
      count_q        <= count_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule

// File: doc/scpool_nch.md
# scpool_nch

Multi-channel pooling comparator: the parametrised successor to the single-channel FP16 max-pool unit. Reads one window of `kernel_size` vectors from an upstream FIFO and reduces each of `CHANNELS` lanes independently to its max or min. Supports signed-integer or IEEE half-float ordering and per-window mode selection, and presents one registered result vector per window. Sits between the input-feature FIFO and the output write-back stage of the pooling layer.

## Interface
Parameters:
- `DATA_WIDTH`, 16: bits per channel element.
- `CHANNELS`, 4: parallel lanes; `data` and `result` are `CHANNELS*DATA_WIDTH` wide, with lane i at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `FLOAT`, 1: 1 = elements are IEEE-754 binary16 (requires `DATA_WIDTH`=16); 0 = signed two's complement.
- `KS_WIDTH`, 8: width of `kernel_size`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a window. Sampled only in IDLE.
- `mode`  in  1  0 = max, 1 = min. Latched on accepted `start`.
- `kernel_size`  in  KS_WIDTH  elements per window. Latched on accepted `start`.
- `fifo_empty`  in  1  upstream FIFO empty flag.
- `reads_en`  out  1  FIFO pop strobe, one cycle per element.
- `data`  in  CHANNELS*DATA_WIDTH  FIFO output vector.
- `data_ready`  in  1  `data` valid this cycle; arrives one or more cycles after `reads_en`.
- `result`  out  CHANNELS*DATA_WIDTH  reduced vector, registered.
- `result_valid`  out  1  one-cycle pulse; `result` valid and held until next window completes.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: `start`=1 and `kernel_size`≠0 → latch `mode` and `kernel_size`, clear `count`, go to REQ. `start` with `kernel_size`=0 is ignored: no state change, no output.
- REQ: if `fifo_empty`=0, assert `reads_en` for exactly one cycle and go to WAIT. Otherwise remain in REQ with `reads_en`=0.
- WAIT: on `data_ready`, update each lane:
  - if `count`==0, load `data` directly; there is no zero seeding, so all-negative windows are correct;
  - otherwise replace the lane value only if the new element is strictly greater (max) or strictly less (min). Ties keep the earlier value.
- After the update in WAIT, if `count`+1 == latched size go to DONE; else increment `count` and go to REQ.
- DONE: copy the accumulators to `result`, pulse `result_valid`, go to IDLE.
- Ordering:
  - `FLOAT`=0: signed compare.
  - `FLOAT`=1: compare on key = sign ? ~x : x^16'h8000. This is a total order: −0 < +0, and NaNs are ordered by bit pattern with no special handling.
- `data_ready` outside WAIT is ignored. `start` while `busy` is ignored.
- `count` is KS_WIDTH bits. The maximum window is 2^KS_WIDTH−1 elements, with no wrap.

## Timing
- Reset values: `reads_en`=0, `result`=0, `result_valid`=0, `busy`=0; state=IDLE; `count` and accumulators cleared.
- Reset mid-window: abandons the window immediately with no `result_valid`. Elements already popped are lost; upstream must flush.
- `reads_en` is never asserted with `fifo_empty`=1. At most one read is outstanding.
- With a non-empty FIFO and `data_ready` one cycle after `reads_en`, each element costs 2 cycles: REQ then WAIT.
- Latency from `start` to `result_valid` = 2·`kernel_size`+2 cycles (1 to leave IDLE, 2 per element, 1 for DONE). FIFO stalls or late `data_ready` add cycles one-for-one.
- `result` updates in the same cycle `result_valid` rises. `busy` falls the cycle after DONE.
- Back-to-back: `start` may be accepted the cycle after `result_valid`.

## Test plan
- Max, FLOAT=1, CHANNELS=4, ks=4; lane0 inputs 0xC000,0xBC00,0xC400,0xC200 (−2,−1,−4,−3) → lane0 result 0xBC00. Checks there is no zero seeding.
- Min, FLOAT=1, lane1 inputs +0 (0x0000), −0 (0x8000), 0x3C00 → lane1 result 0x8000. Tie/order rule holds.
- FLOAT=0, DATA_WIDTH=8, max, inputs 0x7F,0x80,0x01 → 0x7F. Min on the same inputs → 0x80.
- ks=3 with `fifo_empty` held high 5 cycles before the 2nd element → `reads_en` stays 0 throughout the stall. Exactly 3 `reads_en` pulses. `result_valid` at cycle 8+5.
- `start` with ks=0 → no `busy` and no `reads_en`. `start` pulsed during a ks=2 window → ignored; exactly one `result_valid`.
- `rst` asserted in WAIT of a ks=4 window after 2 elements → all outputs zero at once. A following ks=1 window with input 0x1234 → `result` lane 0x1234, with `result_valid` 4 cycles after `start`.
